// File: rtl/key_pkg.sv
// Shared keypad constants, press-state encoding and key-code helpers
// for the key event queue.
package key_pkg;

    localparam int KEY_ROWS   = 5;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 5;
    localparam int HOLE_W     = 5;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HELD     = 2'd1,
        WAIT_REL = 2'd2
    } press_state_t;

    // Rows 5..7 do not exist on the keypad.
    function automatic logic code_valid(input logic [KEY_CODE_W-1:0] code);
        return code[4:2] <= 3'(KEY_ROWS - 1);
    endfunction

    // row*4 + col, kept in 5 bits (max 19).
    function automatic logic [HOLE_W-1:0] code_to_hole(input logic [KEY_CODE_W-1:0] code);
        return {code[4:2], 2'b00} + {3'b000, code[1:0]};
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Generic synchronous FIFO with separate occupancy count. A push into a
// full FIFO is accepted only when a pop happens on the same edge.
module key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key-down levels into one event per distinct press, with a
// release hold-off, and queues {code, hole} events for the game FSM.
module key_event_queue
    import key_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [KEY_CODE_W-1:0]   key_code,
    input  logic                    key_ready,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [KEY_CODE_W-1:0]   evt_code,
    output logic [HOLE_W-1:0]       evt_hole,
    output logic [$clog2(DEPTH):0]  evt_count,
    output logic                    overflow,
    input  logic                    ovf_clr
);
    localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);

    // Valid/ready: an event transfers on a clock edge where evt_valid and
    // evt_ready are both high; the head is held stable until then.
    press_state_t                 press_state, press_state_d;
    logic         [CNT_W-1:0]     rel_cnt, rel_cnt_d;
    logic                         press_det;
    logic                         push_req;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [KEY_CODE_W+HOLE_W-1:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_state <= WAIT_REL;
            rel_cnt     <= '0;
        end else begin
            press_state <= press_state_d;
            rel_cnt     <= rel_cnt_d;
        end
    end

    always_comb begin
        press_state_d = press_state;
        rel_cnt_d     = rel_cnt;
        press_det     = 1'b0;
        case (press_state)
            ARMED: begin
                if (key_ready) begin
                    press_det     = 1'b1;
                    press_state_d = HELD;
                end
            end
            HELD: begin
                // The first low cycle already counts toward the hold-off.
                if (!key_ready) begin
                    rel_cnt_d     = CNT_W'(1);
                    press_state_d = (RELEASE_CYCLES <= 1) ? ARMED : WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (key_ready) begin
                    press_state_d = HELD;
                    rel_cnt_d     = '0;
                end else begin
                    rel_cnt_d = rel_cnt + 1'b1;
                    if (rel_cnt_d >= CNT_W'(RELEASE_CYCLES)) press_state_d = ARMED;
                end
            end
            default: begin
                press_state_d = WAIT_REL;
                rel_cnt_d     = '0;
            end
        endcase
    end

    assign push_req = press_det && code_valid(key_code);

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_CODE_W + HOLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_req),
        .wr_data ({key_code, code_to_hole(key_code)}),
        .pop     (evt_ready),
        .rd_data (rd_data),
        .count   (evt_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = rd_data[KEY_CODE_W+HOLE_W-1:HOLE_W];
    assign evt_hole  = rd_data[HOLE_W-1:0];

    // A full FIFO is never empty, so evt_ready alone means a pop this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                overflow <= 1'b0;
        else if (ovf_clr)                          overflow <= 1'b0;
        else if (push_req && fifo_full && !evt_ready) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed and randomized checks of key_event_queue against a press/queue
// reference model kept in the bench.
module tb_key_event_queue;
    localparam int DEPTH = 4;
    localparam int REL   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key_code = '0;
    logic       key_ready = 1'b0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [4:0] evt_code;
    logic [4:0] evt_hole;
    logic [2:0] evt_count;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [9:0] exp_q[$];
    bit         m_armed;
    int         m_low_run;
    bit         m_ovf;

    key_event_queue #(.DEPTH(DEPTH), .RELEASE_CYCLES(REL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_code  (key_code),
        .key_ready (key_ready),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_hole  (evt_hole),
        .evt_count (evt_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] make_entry(input logic [4:0] code);
        int row = int'(code) / 4;
        int col = int'(code) % 4;
        logic [4:0] hole = 5'(row * 4 + col);
        return {code, hole};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_armed   = 0;
        m_low_run = 0;
        m_ovf     = 0;
    endtask

    // One clock edge worth of behaviour, from the inputs currently applied.
    task automatic model_edge(input logic kr, input logic [4:0] code, input logic er, input logic oc);
        bit was_full = (exp_q.size() == DEPTH);
        bit do_pop   = (exp_q.size() > 0) && er;
        bit accept   = kr && m_armed;
        bit valid    = accept && ((int'(code) / 4) <= 4);
        bit drop     = valid && was_full && !do_pop;
        if (kr) begin
            m_armed   = 0;
            m_low_run = 0;
        end else begin
            m_low_run++;
            if (m_low_run >= REL) m_armed = 1;
        end
        if (do_pop) void'(exp_q.pop_front());
        if (valid && !drop) exp_q.push_back(make_entry(code));
        if (oc) m_ovf = 0;
        else if (drop) m_ovf = 1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, 32'(evt_count), 32'(exp_q.size()));
        check({tag, "_valid"}, 32'(evt_valid), 32'(exp_q.size() > 0));
        check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
        if (exp_q.size() > 0) begin
            check({tag, "_code"}, 32'(evt_code), 32'(exp_q[0][9:5]));
            check({tag, "_hole"}, 32'(evt_hole), 32'(exp_q[0][4:0]));
        end
    endtask

    // Called at a negedge; returns at the following negedge after checking.
    task automatic step(input logic kr, input logic [4:0] code, input logic er, input logic oc);
        key_ready = kr;
        key_code  = code;
        evt_ready = er;
        ovf_clr   = oc;
        model_edge(kr, code, er, oc);
        @(posedge clk);
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'h00, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [4:0] code, input logic er);
        step(1'b1, code, er, 1'b0);
    endtask

    task automatic do_reset(input logic kr);
        @(negedge clk);
        rst_n     = 1'b0;
        key_ready = kr;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_code",  32'(evt_code),  32'd0);
        check("rst_hole",  32'(evt_hole),  32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seg_len;
        logic seg_lvl;

        model_reset();

        // Basic press: event one cycle after detection, no auto-repeat.
        do_reset(1'b0);
        idle(REL);
        check("t1_pre_valid", 32'(evt_valid), 32'd0);
        press(5'h0E, 1'b0);
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_hole",  32'(evt_hole),  32'd14);
        check("t1_code",  32'(evt_code),  32'h0E);
        for (int i = 0; i < 100; i++) press(5'($urandom_range(0, 19)), 1'b0);
        check("t1_no_repeat", 32'(evt_count), 32'd1);

        // Bounce during release produces no second event.
        do_reset(1'b0);
        idle(REL);
        press(5'h0E, 1'b0);
        press(5'h0E, 1'b0);
        idle(10);
        press(5'h0E, 1'b0);
        press(5'h0E, 1'b0);
        idle(REL + 4);
        press(5'h00, 1'b0);
        step(1'b0, 5'h00, 1'b0, 1'b0);
        check("t2_count", 32'(evt_count), 32'd2);
        check("t2_first", 32'(evt_hole),  32'd14);
        step(1'b0, 5'h00, 1'b1, 1'b0);
        check("t2_second", 32'(evt_hole), 32'd0);

        // Key held through reset.
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) press(5'h05, 1'b0);
        check("t3_held", 32'(evt_count), 32'd0);
        idle(REL - 1);
        press(5'h05, 1'b0);
        check("t3_early", 32'(evt_count), 32'd0);
        idle(REL);
        press(5'h05, 1'b0);
        check("t3_after", 32'(evt_count), 32'd1);
        check("t3_hole",  32'(evt_hole),  32'd5);

        // Invalid row is not pushed but still needs a release.
        do_reset(1'b0);
        idle(REL);
        press(5'h1F, 1'b0);
        check("t4_invalid", 32'(evt_count), 32'd0);
        idle(5);
        press(5'h03, 1'b0);
        check("t4_not_armed", 32'(evt_count), 32'd0);
        idle(REL);
        press(5'h13, 1'b0);
        check("t4_valid", 32'(evt_hole), 32'd19);

        // Overflow with five presses, ordered drain, then clear.
        do_reset(1'b0);
        begin
            logic [4:0] codes [5];
            codes = '{5'h01, 5'h06, 5'h0B, 5'h10, 5'h12};
            for (int i = 0; i < 5; i++) begin
                idle(REL);
                press(codes[i], 1'b0);
            end
            check("t5_count", 32'(evt_count), 32'd4);
            check("t5_ovf",   32'(overflow),  32'd1);
            check("t5_h0", 32'(evt_hole), 32'd1);
            step(1'b0, 5'h00, 1'b1, 1'b0);
            check("t5_h1", 32'(evt_hole), 32'd6);
            step(1'b0, 5'h00, 1'b1, 1'b0);
            check("t5_h2", 32'(evt_hole), 32'd11);
            step(1'b0, 5'h00, 1'b1, 1'b0);
            check("t5_h3", 32'(evt_hole), 32'd16);
            step(1'b0, 5'h00, 1'b1, 1'b1);
            check("t5_clr",   32'(overflow),  32'd0);
            check("t5_empty", 32'(evt_valid), 32'd0);
        end

        // Full FIFO: push with simultaneous pop, then clear-vs-drop priority.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(REL);
            press(5'(i), 1'b0);
        end
        idle(REL);
        press(5'h08, 1'b1);
        check("t6_count", 32'(evt_count), 32'd4);
        check("t6_head",  32'(evt_hole),  32'd1);
        check("t6_ovf",   32'(overflow),  32'd0);
        idle(REL);
        step(1'b1, 5'h09, 1'b0, 1'b1);
        check("t7_clr_wins", 32'(overflow), 32'd0);
        check("t7_count",    32'(evt_count), 32'd4);

        // Randomized segments of key levels, with one mid-run reset.
        do_reset(1'b0);
        for (int seg = 0; seg < 300; seg++) begin
            seg_lvl = 1'($urandom_range(0, 1));
            seg_len = seg_lvl ? $urandom_range(1, 4) : $urandom_range(1, 22);
            for (int c = 0; c < seg_len; c++)
                step(seg_lvl, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 15) == 0));
            if (seg == 150) do_reset(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Consumes the filtered keypad scanner output: 5-bit key code, `[4:2]` = row 0..4, `[1:0]` = column 0..3, plus a debounced ready level.
- Converts each distinct press into exactly one event, with no auto-repeat and a release hold-off.
- Maps the event to a hole index and buffers events in a small FIFO.
- The game-logic FSM drains the FIFO through a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RELEASE_CYCLES, 16, consecutive key_ready-low cycles required before the next press is accepted; at least 1.

Ports:
- clk  input  1  system clock, the same clock as the keypad scanner.
- rst_n  input  1  asynchronous active-low reset.
- key_code  input  5  scanner key code; meaningful only while key_ready=1.
- key_ready  input  1  debounced key-down level from the scanner.
- evt_valid  output  1  FIFO non-empty; a head event is available.
- evt_ready  input  1  consumer accepts the head event this cycle.
- evt_code  output  5  head event raw key code.
- evt_hole  output  5  head event hole index, row*4+col, range 0..19.
- evt_count  output  $clog2(DEPTH)+1  number of queued events.
- overflow  output  1  sticky flag; set when a valid press is dropped because the FIFO is full.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (async, rst_n=0):
  - State is WAIT_REL with the release counter at 0.
  - FIFO is empty, so evt_valid=0 and evt_count=0.
  - evt_code=0, evt_hole=0, overflow=0.
- Press FSM states: ARMED, HELD, WAIT_REL.
  - ARMED with key_ready=1 → press detected this cycle. Next state is HELD. If the code is valid, push {key_code, hole}.
  - ARMED with key_ready=0 → stay in ARMED.
  - HELD with key_ready=0 → WAIT_REL, counter set to 1.
  - HELD with key_ready=1 → stay in HELD. Code changes while held are ignored.
  - WAIT_REL with key_ready=1 → HELD, counter cleared. A bounce never produces a second event.
  - WAIT_REL with key_ready=0 → counter increments. When the counter reaches RELEASE_CYCLES, go to ARMED.
- Reset state is WAIT_REL, so a key held through reset produces no event until it has been released for RELEASE_CYCLES cycles.
- Valid code: key_code[4:2] ≤ 4. Rows 5..7 are invalid. An invalid code still moves the FSM to HELD but is never pushed.
- Hole index = key_code[4:2]*4 + key_code[1:0]. Computed in 5 bits; maximum value is 19.
- Latency: a press detected in cycle N is written at the end of cycle N. If the FIFO was empty, evt_valid=1 from cycle N+1.
- Pop occurs when evt_valid & evt_ready on a clock edge. evt_code/evt_hole always show the head entry and are stable while evt_valid=1 and evt_ready=0.
- Full FIFO:
  - A push without a simultaneous pop is dropped; evt_count stays at DEPTH and overflow is set.
  - A push with a simultaneous pop on the same edge is accepted; count is unchanged.
- Empty FIFO:
  - evt_ready is ignored.
  - A push into an empty FIFO is visible the next cycle; there is no bypass path.
- Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. evt_count is tracked separately, from 0 to DEPTH.
- overflow: ovf_clr has priority. If ovf_clr=1 and an overflow drop happen in the same cycle, overflow reads 0 next cycle.
- Reset asserted mid-operation flushes the queue, returns the FSM to WAIT_REL, and clears overflow.

Decomposition:
- Package key_pkg holds:
  - KEY_ROWS=5 and KEY_COLS=4.
  - KEY_CODE_W=5 and HOLE_W=5.
  - Press-state enum {ARMED, HELD, WAIT_REL}.
  - Function code_to_hole(code).
  - Function code_valid(code).
- One sub-module: key_evt_fifo, a generic synchronous FIFO.
  - Parameters: DEPTH and WIDTH=10.
  - Ports: push, pop, data, count, full, empty.
  - The press FSM and overflow logic stay in the top module.

Test Plan:
- After reset, key_ready=0 for 16 cycles, then key_ready=1 with key_code=5'b01110 (row 3, col 2) → evt_valid=1 exactly one cycle after detection, evt_hole=14, evt_code=0x0E. Holding the key for 100 cycles produces no second event.
- Bounce during release: press, release for 10 cycles, re-assert, release for 16+ cycles, press code 0x00 → exactly two events queued, holes 14 then 0.
- Key held through reset: key_ready=1 during and after rst_n deassertion → no event until key_ready has been low for 16 cycles and then rises.
- Invalid row: key_code=5'b11111 with key_ready=1 while ARMED → no push and evt_count=0. The FSM still requires a release before the next press is accepted.
- Overflow (evt_ready=0): five valid presses → evt_count=4, overflow=1, and popping returns the first four holes in order. Then assert ovf_clr → overflow=0.
- Full FIFO with simultaneous push and pop on the same edge → push accepted, evt_count stays 4, and the head advances to the second entry.
